// File: rtl/vga_line_prefetch.sv
// Ping-pong line buffer: fetches the next display line's source row during hblank
// and serves 4x-upscaled RGB332 pixels during active video, all in the pixel clock domain.
module vga_line_prefetch #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
    parameter int          FB_W       = 160,
    parameter int          FB_H       = 120,
    parameter int          SCALE_LOG2 = 2,
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          H_TOTAL    = 800,
    parameter int          V_TOTAL    = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [31:0] ReadData,
    output logic [31:0] DataAdr,
    output logic        mem_rd,
    output logic [7:0]  pix,
    output logic        pix_active,
    output logic        fetch_busy,
    output logic        underrun
);

    localparam int WPL = FB_W / 4;
    localparam int KW  = $clog2(WPL);
    localparam int RW  = $clog2(FB_H);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state, state_d;
    logic [RW-1:0]   row;
    logic [KW-1:0]   k;
    logic            wbank;
    logic            cap_vld;
    logic [KW-1:0]   cap_k;
    logic [31:0]     line_buf [2][WPL];

    logic [9:0]      next_y;
    logic            trigger, abort, last_req;

    assign next_y   = (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
    assign trigger  = (x == 10'(H_ACTIVE)) && (next_y < 10'(V_ACTIVE)) && (state == IDLE);
    // A fetch still running at the last column of the line has missed its window.
    assign abort    = (state != IDLE) && (x == 10'(H_TOTAL - 1));
    assign last_req = (state == REQ) && (k == KW'(WPL - 1));

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (trigger) state_d = REQ;
            REQ:     if (last_req) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // FSM: outputs
    always_comb begin
        mem_rd     = (state == REQ);
        fetch_busy = (state != IDLE);
    end

    // row/k hold their last values outside REQ, so the address holds too.
    assign DataAdr = BASE_ADDR + ((32'(row) * 32'(WPL) + 32'(k)) << 2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row      <= '0;
            k        <= '0;
            wbank    <= 1'b0;
            cap_vld  <= 1'b0;
            cap_k    <= '0;
            underrun <= 1'b0;
        end else begin
            if (trigger) begin
                row   <= RW'(next_y >> SCALE_LOG2);
                wbank <= next_y[0];
                k     <= '0;
            end else if ((state == REQ) && !last_req && !abort) begin
                k <= k + KW'(1);
            end
            cap_vld <= mem_rd && !abort;
            cap_k   <= k;
            if (abort) underrun <= 1'b1;
        end
    end

    // Sync-read data lands one cycle after its request; aborted words are dropped.
    always_ff @(posedge clk) begin
        if (cap_vld && !abort) line_buf[wbank][cap_k] <= ReadData;
    end

    logic            active;
    logic [9:0]      col;
    logic [KW-1:0]   rd_word;
    logic [1:0]      rd_byte;
    logic [31:0]     rd_data;
    logic [7:0]      rd_pix;

    always_comb begin
        active  = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
        col     = x >> SCALE_LOG2;
        rd_word = active ? KW'(col >> 2) : '0;
        rd_byte = col[1:0];
        rd_data = line_buf[y[0]][rd_word];
        rd_pix  = rd_data[8*rd_byte +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix        <= 8'd0;
            pix_active <= 1'b0;
        end else begin
            pix        <= active ? rd_pix : 8'd0;
            pix_active <= active;
        end
    end

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Directed + randomized bench for vga_line_prefetch against a framebuffer/bank-contents model.
module tb_vga_line_prefetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic [31:0] ReadData = 32'd0;
    logic [31:0] DataAdr;
    logic        mem_rd;
    logic [7:0]  pix;
    logic        pix_active;
    logic        fetch_busy;
    logic        underrun;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] fb_mem [0:4799];
    int          bank_row [2];
    int unsigned midx;

    vga_line_prefetch dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .ReadData(ReadData),
        .DataAdr(DataAdr), .mem_rd(mem_rd), .pix(pix), .pix_active(pix_active),
        .fetch_busy(fetch_busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Sync-read memory: data valid the cycle after the request.
    always @(posedge clk) begin
        if (mem_rd) begin
            midx = (DataAdr - 32'h2000) >> 2;
            ReadData <= (midx < 4800) ? fb_mem[midx] : 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int xv, input int yv);
        int r, c;
        logic [31:0] w;
        if (xv >= 640 || yv >= 480) return 8'd0;
        r = bank_row[yv % 2];
        c = xv / 4;
        w = fb_mem[r * 40 + c / 4];
        return w[8 * (c % 4) +: 8];
    endfunction

    task automatic run_fetch(input int yv, input bit expect_fetch);
        int nrd = 0;
        int nbusy = 0;
        int ny = (yv == 524) ? 0 : yv + 1;
        int r = ny / 4;
        y = 10'(yv);
        x = 10'd640;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (mem_rd) begin
                chk("fetch_addr", DataAdr, 32'h2000 + 32'((r * 40 + nrd) * 4));
                nrd++;
            end
            if (fetch_busy) nbusy++;
            x = x + 10'd1;
        end
        chk("fetch_rd_cycles", 32'(nrd), expect_fetch ? 32'd40 : 32'd0);
        chk("fetch_busy_cycles", 32'(nbusy), expect_fetch ? 32'd41 : 32'd0);
        if (expect_fetch) bank_row[ny % 2] = r;
    endtask

    task automatic disp(input int xv);
        bit act;
        x = 10'(xv);
        @(posedge clk); #1;
        act = (xv < 640) && (int'(y) < 480);
        chk("pix_active", {31'd0, pix_active}, {31'd0, act});
        if (!act || bank_row[y % 2] >= 0)
            chk("pix", {24'd0, pix}, {24'd0, exp_pix(xv, int'(y))});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_adr"}, DataAdr, 32'h2000);
        chk({tag, "_rd"}, {31'd0, mem_rd}, 32'd0);
        chk({tag, "_pix"}, {24'd0, pix}, 32'd0);
        chk({tag, "_act"}, {31'd0, pix_active}, 32'd0);
        chk({tag, "_busy"}, {31'd0, fetch_busy}, 32'd0);
        chk({tag, "_unr"}, {31'd0, underrun}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        x = 10'd100;
        y = 10'd100;
        for (int i = 0; i < 4800; i++) fb_mem[i] = $urandom;
        fb_mem[40] = 32'h4433_2211;
        bank_row[0] = -1;
        bank_row[1] = -1;
        #1;
        chk_reset_outputs("rst0");
        @(posedge clk); #1;
        reset = 1'b1;

        // line 0 fetch fills bank 1 with row 0
        run_fetch(0, 1'b1);
        y = 10'd1;
        for (int i = 0; i < 12; i++) disp($urandom_range(0, 639));

        // row 1 into bank 0, displayed on line 4
        run_fetch(3, 1'b1);
        y = 10'd4;
        for (int xv = 0; xv < 8; xv++) begin
            disp(xv);
            chk("row1_word0", {24'd0, pix}, (xv < 4) ? 32'h11 : 32'h22);
        end

        // last active line: no fetch
        run_fetch(479, 1'b0);

        // frame wrap fetches row 0 into bank 0
        run_fetch(524, 1'b1);
        y = 10'd0;
        for (int i = 0; i < 8; i++) disp($urandom_range(0, 639));
        disp(700);

        for (int n = 0; n < 12; n++) begin
            int yd = $urandom_range(1, 479);
            run_fetch(yd - 1, 1'b1);
            y = 10'(yd);
            for (int i = 0; i < 8; i++) disp($urandom_range(0, 639));
            disp($urandom_range(641, 798));
        end
        y = 10'($urandom_range(480, 523));
        for (int i = 0; i < 4; i++) disp($urandom_range(0, 639));

        // underrun: jump to end of line mid-fetch
        y = 10'd10;
        x = 10'd640;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            x = 10'(640 + i);
        end
        @(posedge clk); #1;
        chk("busy_before_jump", {31'd0, fetch_busy}, 32'd1);
        chk("unr_before_jump", {31'd0, underrun}, 32'd0);
        x = 10'd799;
        @(posedge clk); #1;
        chk("underrun_set", {31'd0, underrun}, 32'd1);
        chk("busy_after_abort", {31'd0, fetch_busy}, 32'd0);
        chk("rd_after_abort", {31'd0, mem_rd}, 32'd0);
        bank_row[1] = -1;
        run_fetch(20, 1'b1);
        chk("underrun_sticky", {31'd0, underrun}, 32'd1);

        // asynchronous reset mid-fetch
        y = 10'd30;
        x = 10'd640;
        @(posedge clk); @(posedge clk); #1;
        chk("rd_before_reset", {31'd0, mem_rd}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        bank_row[1] = -1;
        @(posedge clk); #1;
        reset = 1'b1;

        run_fetch(40, 1'b1);
        y = 10'd41;
        for (int i = 0; i < 6; i++) disp($urandom_range(0, 639));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
